// File: rtl/avst_debug_packet_fifo.sv
// Store-and-forward Avalon-ST packet FIFO for the debug stream path.
// A packet becomes visible on the source side only once its EOP beat is committed.
module avst_debug_packet_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_startofpacket,
    input  logic                  in_endofpacket,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_startofpacket,
    output logic                  out_endofpacket,
    output logic [DEPTH_LOG2:0]   level,
    output logic [CNT_W-1:0]      drop_count,
    output logic                  overflow
);
    localparam int unsigned DEPTH  = 2 ** DEPTH_LOG2;
    localparam int unsigned PTR_W  = DEPTH_LOG2 + 1;
    localparam int unsigned WORD_W = DATA_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_PKT, S_DISCARD} wr_state_e;

    wr_state_e          state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   wr_commit_q, wr_commit_d;
    logic [PTR_W-1:0]   commit_rd_q;
    logic [PTR_W-1:0]   fetch_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_addr_c;
    logic [WORD_W-1:0]  mem [DEPTH];
    logic [WORD_W-1:0]  rd_word_c;
    logic               beat_c, we_c, drop_c;
    logic               full_c, full_rb_c;
    logic               load_c, pop_c, sop_next_q;

    assign beat_c    = in_valid & in_ready;
    assign full_c    = (wr_ptr_q - rd_ptr_q) == PTR_W'(DEPTH);
    assign full_rb_c = (wr_commit_q - rd_ptr_q) == PTR_W'(DEPTH);

    // Write FSM state register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state_q <= S_IDLE;
        else                state_q <= state_d;
    end

    // Write FSM next state
    always_comb begin
        state_d = state_q;
        if (beat_c) begin
            case (state_q)
                S_IDLE, S_DISCARD: begin
                    if (in_startofpacket)
                        state_d = in_endofpacket ? S_IDLE : (full_c ? S_DISCARD : S_PKT);
                    else if (state_q == S_DISCARD && in_endofpacket)
                        state_d = S_IDLE;
                end
                S_PKT: begin
                    if (in_startofpacket)
                        state_d = in_endofpacket ? S_IDLE : (full_rb_c ? S_DISCARD : S_PKT);
                    else if (in_endofpacket)
                        state_d = S_IDLE;
                    else if (full_c)
                        state_d = S_DISCARD;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Write FSM outputs: RAM write, pointer moves, drop strobe
    always_comb begin
        we_c        = 1'b0;
        drop_c      = 1'b0;
        wr_addr_c   = wr_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        if (beat_c) begin
            case (state_q)
                S_IDLE, S_DISCARD: begin
                    if (in_startofpacket) begin
                        if (full_c) begin
                            drop_c = 1'b1;
                        end else begin
                            we_c     = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_W'(1);
                            if (in_endofpacket) wr_commit_d = wr_ptr_q + PTR_W'(1);
                        end
                    end
                end
                S_PKT: begin
                    if (in_startofpacket) begin
                        // Abandon the open packet and restart at the commit point
                        drop_c   = 1'b1;
                        wr_ptr_d = wr_commit_q;
                        if (!full_rb_c) begin
                            we_c      = 1'b1;
                            wr_addr_c = wr_commit_q;
                            wr_ptr_d  = wr_commit_q + PTR_W'(1);
                            if (in_endofpacket) wr_commit_d = wr_commit_q + PTR_W'(1);
                        end
                    end else if (full_c) begin
                        drop_c   = 1'b1;
                        wr_ptr_d = wr_commit_q;
                    end else begin
                        we_c     = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        if (in_endofpacket) wr_commit_d = wr_ptr_q + PTR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (we_c) mem[wr_addr_c[DEPTH_LOG2-1:0]] <= {in_endofpacket, in_data};
    end

    // rd_ptr releases a slot only when the source handshake consumes it
    assign rd_word_c = mem[fetch_ptr_q[DEPTH_LOG2-1:0]];
    assign pop_c     = out_valid & out_ready;
    assign load_c    = (fetch_ptr_q != commit_rd_q) && (!out_valid || out_ready);
    assign rd_ptr_d  = rd_ptr_q + PTR_W'(pop_c);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            in_ready          <= 1'b0;
            wr_ptr_q          <= '0;
            wr_commit_q       <= '0;
            commit_rd_q       <= '0;
            fetch_ptr_q       <= '0;
            rd_ptr_q          <= '0;
            level             <= '0;
            drop_count        <= '0;
            overflow          <= 1'b0;
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            sop_next_q        <= 1'b1;
        end else begin
            in_ready    <= 1'b1;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            commit_rd_q <= wr_commit_q;
            rd_ptr_q    <= rd_ptr_d;
            level       <= wr_ptr_d - rd_ptr_d;
            overflow    <= drop_c;
            if (drop_c && drop_count != '1) drop_count <= drop_count + CNT_W'(1);
            if (load_c) begin
                fetch_ptr_q       <= fetch_ptr_q + PTR_W'(1);
                out_valid         <= 1'b1;
                out_data          <= rd_word_c[DATA_W-1:0];
                out_endofpacket   <= rd_word_c[DATA_W];
                out_startofpacket <= sop_next_q;
                sop_next_q        <= rd_word_c[DATA_W];
            end else if (pop_c) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_avst_debug_packet_fifo.sv
// Scoreboard bench for avst_debug_packet_fifo with a 16-word buffer.
module tb_avst_debug_packet_fifo;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int unsigned CNT_W      = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [DATA_W-1:0]   in_data = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic                in_sop = 1'b0;
    logic                in_eop = 1'b0;
    logic [DATA_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic                out_sop;
    logic                out_eop;
    logic [DEPTH_LOG2:0] level;
    logic [CNT_W-1:0]    drop_count;
    logic                overflow;

    int checks = 0;
    int fails = 0;
    int ovf_seen = 0;
    logic [DATA_W+1:0] sb_q[$];

    always #5 clk = ~clk;

    avst_debug_packet_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .CNT_W(CNT_W)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_startofpacket(in_sop), .in_endofpacket(in_eop),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_startofpacket(out_sop), .out_endofpacket(out_eop),
        .level(level), .drop_count(drop_count), .overflow(overflow)
    );

    // Compare any source handshake about to happen, then advance one clock
    task automatic cycle();
        logic [DATA_W+1:0] exp_w;
        if (out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL out_unexpected: got sop=%0b eop=%0b data=%h, expected nothing", out_sop, out_eop, out_data);
            end else begin
                exp_w = sb_q.pop_front();
                if ({out_sop, out_eop, out_data} !== exp_w) begin
                    fails++;
                    $display("FAIL out_word: got sop=%0b eop=%0b data=%h, expected sop=%0b eop=%0b data=%h",
                             out_sop, out_eop, out_data, exp_w[DATA_W+1], exp_w[DATA_W], exp_w[DATA_W-1:0]);
                end
            end
        end
        @(posedge clk);
        #1;
        if (overflow) ovf_seen++;
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic sop, input logic eop, input bit keep);
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = sop;
        in_eop   = eop;
        if (keep) sb_q.push_back({sop, eop, d});
        cycle();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sb_q.size() != 0 || out_valid) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (sb_q.size() != 0 || out_valid) begin
            fails++;
            $display("FAIL %s_drain: %0d words still expected, out_valid=%0b after %0d cycles", name, sb_q.size(), out_valid, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, out_sop, out_eop, out_data, level, drop_count, overflow} !== '0) begin
            fails++;
            $display("FAIL reset_state: rdy=%0b ov=%0b sop=%0b eop=%0b data=%h level=%0d drops=%0d ovf=%0b, expected all 0",
                     in_ready, out_valid, out_sop, out_eop, out_data, level, drop_count, overflow);
        end
        rst_n = 1'b1;
        cycle();
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %0b, expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) send_beat(8'h11 + 8'(i), i == 0, i == 3, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_lat_n: out_valid=%0b at EOP edge, expected 0", out_valid);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_lat_n1: out_valid=%0b one cycle after EOP, expected 0", out_valid);
        end
        cycle();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1) begin
                fails++;
                $display("FAIL basic_stream: out_valid=%0b at word %0d, expected 1", out_valid, i);
            end
            cycle();
        end
        checks++;
        if (out_valid !== 1'b0 || sb_q.size() != 0) begin
            fails++;
            $display("FAIL basic_end: out_valid=%0b pending=%0d, expected 0 and 0", out_valid, sb_q.size());
        end
    endtask

    task automatic test_oversize();
        int ovf0 = ovf_seen;
        for (int i = 0; i < 20; i++) send_beat(8'h40 + 8'(i), i == 0, i == 19, 1'b0);
        for (int i = 0; i < 3; i++) send_beat(8'hA0 + 8'(i), i == 0, i == 2, 1'b1);
        drain(50, "oversize");
        repeat (2) cycle();
        checks++;
        if (drop_count !== 16'd1) begin
            fails++;
            $display("FAIL oversize_drops: got %0d, expected 1", drop_count);
        end
        checks++;
        if (ovf_seen - ovf0 != 1) begin
            fails++;
            $display("FAIL oversize_pulse: got %0d overflow cycles, expected 1", ovf_seen - ovf0);
        end
        checks++;
        if (level !== '0) begin
            fails++;
            $display("FAIL oversize_level: got %0d, expected 0", level);
        end
    endtask

    task automatic test_missing_eop();
        logic [CNT_W-1:0] d0 = drop_count;
        send_beat(8'h5A, 1'b1, 1'b0, 1'b0);
        send_beat(8'h5B, 1'b0, 1'b0, 1'b0);
        send_beat(8'hC1, 1'b1, 1'b0, 1'b1);
        send_beat(8'hD1, 1'b0, 1'b1, 1'b1);
        drain(30, "missing_eop");
        checks++;
        if (drop_count !== d0 + 16'd1) begin
            fails++;
            $display("FAIL missing_eop_drops: got %0d, expected %0d", drop_count, d0 + 16'd1);
        end
    endtask

    task automatic test_stall();
        logic [DATA_W+2:0] held;
        bit                hold_chk;
        int                n = 0;
        out_ready = 1'b0;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 8; i++) send_beat(8'(8'h60 + 16 * p + i), i == 0, i == 7, 1'b1);
        repeat (3) cycle();
        checks++;
        if (level !== 5'd16) begin
            fails++;
            $display("FAIL stall_level_full: got %0d, expected 16", level);
        end
        while ((sb_q.size() != 0 || out_valid) && n < 100) begin
            out_ready = (n % 2) == 1;
            hold_chk  = out_valid && !out_ready;
            held      = {out_valid, out_sop, out_eop, out_data};
            cycle();
            if (hold_chk) begin
                checks++;
                if ({out_valid, out_sop, out_eop, out_data} !== held) begin
                    fails++;
                    $display("FAIL stall_hold: got v=%0b sop=%0b eop=%0b data=%h, expected v=%0b sop=%0b eop=%0b data=%h",
                             out_valid, out_sop, out_eop, out_data, held[10], held[9], held[8], held[7:0]);
                end
            end
            n++;
        end
        drain(10, "stall");
        checks++;
        if (level !== '0) begin
            fails++;
            $display("FAIL stall_level_empty: got %0d, expected 0", level);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send_beat(8'h70 + 8'(i), i == 0, i == 5, 1'b1);
        while (sb_q.size() > 4 && n < 20) begin
            cycle();
            n++;
        end
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        checks++;
        if (out_valid !== 1'b0 || level !== '0 || drop_count !== '0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_clear: ov=%0b level=%0d drops=%0d rdy=%0b, expected 0 0 0 0",
                     out_valid, level, drop_count, in_ready);
        end
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        send_beat(8'h81, 1'b1, 1'b0, 1'b1);
        send_beat(8'h82, 1'b0, 1'b1, 1'b1);
        drain(20, "reset_mid");
    endtask

    task automatic test_no_sop();
        logic [CNT_W-1:0] d0 = drop_count;
        for (int i = 0; i < 3; i++) begin
            send_beat(8'h90 + 8'(i), 1'b0, i == 2, 1'b0);
            checks++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL no_sop_ready: got %0b, expected 1", in_ready);
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL no_sop_output: out_valid=%0b, expected 0", out_valid);
            end
            cycle();
        end
        checks++;
        if (drop_count !== d0 || level !== '0) begin
            fails++;
            $display("FAIL no_sop_stats: drops=%0d level=%0d, expected %0d and 0", drop_count, level, d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_oversize();
        test_missing_eop();
        test_stall();
        test_reset_mid();
        test_no_sop();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
